// File: rtl/add_rs_dispatch.sv
// Add/sub reservation station: captures operands at issue or from the CDB,
// dispatches one ready op per cycle and frees entries on exec completion.
module add_rs_dispatch #(
  parameter int NUM_RS = 3,
  parameter int DATA_W = 8,
  parameter int TAG_W  = 3,
  parameter int REG_W  = 4,
  localparam int IDX_W = (NUM_RS > 1) ? $clog2(NUM_RS) : 1
) (
  input  logic              clk1,
  input  logic              reset,
  input  logic              alloc_v,
  output logic              alloc_rdy,
  input  logic [3:0]        alloc_func,
  input  logic [REG_W-1:0]  alloc_rd,
  input  logic [TAG_W-1:0]  alloc_rob,
  input  logic              alloc_q1_v,
  input  logic [DATA_W-1:0] alloc_v1,
  input  logic [TAG_W-1:0]  alloc_t1,
  input  logic              alloc_q2_v,
  input  logic [DATA_W-1:0] alloc_v2,
  input  logic [TAG_W-1:0]  alloc_t2,
  input  logic              cdb_v,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  input  logic              ex_rdy,
  output logic              ex_b,
  output logic [IDX_W-1:0]  rs_index,
  output logic [DATA_W-1:0] rs1_data,
  output logic [DATA_W-1:0] rs2_data,
  output logic [3:0]        func,
  output logic [TAG_W-1:0]  rob_ind,
  output logic [REG_W-1:0]  rd,
  input  logic              done_v,
  input  logic [IDX_W-1:0]  done_idx,
  output logic [IDX_W:0]    busy_count
);

  localparam logic [3:0] FN_ADD = 4'b0000;
  localparam logic [3:0] FN_SUB = 4'b0001;
  localparam logic [IDX_W:0] ONE = 1;

  typedef enum logic [1:0] {
    S_FREE,
    S_WAIT,
    S_READY,
    S_EXEC
  } st_e;

  typedef struct packed {
    st_e               st;
    logic [3:0]        func;
    logic [REG_W-1:0]  rd;
    logic [TAG_W-1:0]  rob;
    logic              q1;
    logic [DATA_W-1:0] v1;
    logic [TAG_W-1:0]  t1;
    logic              q2;
    logic [DATA_W-1:0] v2;
    logic [TAG_W-1:0]  t2;
  } ent_t;

  ent_t ent_q [NUM_RS];
  ent_t ent_d [NUM_RS];

  ent_t             new_ent;
  ent_t             sel_ent;
  logic             free_hit;
  logic [IDX_W-1:0] free_idx;
  logic             rdy_hit;
  logic [IDX_W-1:0] rdy_idx;
  logic             func_ok;
  logic             alloc_go;
  logic             disp_go;
  logic             byp1;
  logic             byp2;
  logic [IDX_W:0]   cnt_d;

  always_comb begin
    func_ok = 1'b0;
    unique case (1'b1)
      (alloc_func == FN_ADD): func_ok = 1'b1;
      (alloc_func == FN_SUB): func_ok = 1'b1;
      default:                func_ok = 1'b0;
    endcase
  end

  // Descending scans leave the lowest matching index.
  always_comb begin
    free_hit = 1'b0;
    free_idx = '0;
    rdy_hit  = 1'b0;
    rdy_idx  = '0;
    sel_ent  = '0;
    for (int i = NUM_RS - 1; i >= 0; i--) begin
      if (ent_q[i].st == S_FREE) begin
        free_hit = 1'b1;
        free_idx = IDX_W'(i);
      end
      if (ent_q[i].st == S_READY) begin
        rdy_hit = 1'b1;
        rdy_idx = IDX_W'(i);
        sel_ent = ent_q[i];
      end
    end
  end

  assign alloc_rdy = free_hit;
  assign alloc_go  = alloc_v & free_hit & func_ok;
  assign disp_go   = ex_rdy & rdy_hit;

  assign byp1 = ~alloc_q1_v & cdb_v & (cdb_tag == alloc_t1);
  assign byp2 = ~alloc_q2_v & cdb_v & (cdb_tag == alloc_t2);

  always_comb begin
    new_ent      = '0;
    new_ent.func = alloc_func;
    new_ent.rd   = alloc_rd;
    new_ent.rob  = alloc_rob;
    new_ent.q1   = alloc_q1_v | byp1;
    new_ent.v1   = alloc_q1_v ? alloc_v1 : cdb_data;
    new_ent.t1   = alloc_t1;
    new_ent.q2   = alloc_q2_v | byp2;
    new_ent.v2   = alloc_q2_v ? alloc_v2 : cdb_data;
    new_ent.t2   = alloc_t2;
    new_ent.st   = (new_ent.q1 && new_ent.q2) ? S_READY : S_WAIT;
  end

  always_comb begin
    cnt_d = '0;
    for (int i = 0; i < NUM_RS; i++) begin
      ent_d[i] = ent_q[i];
      unique case (ent_q[i].st)
        S_FREE: begin
          if (alloc_go && free_idx == IDX_W'(i))
            ent_d[i] = new_ent;
        end
        S_WAIT: begin
          if (!ent_q[i].q1 && cdb_v &&
              cdb_tag == ent_q[i].t1) begin
            ent_d[i].q1 = 1'b1;
            ent_d[i].v1 = cdb_data;
          end
          if (!ent_q[i].q2 && cdb_v &&
              cdb_tag == ent_q[i].t2) begin
            ent_d[i].q2 = 1'b1;
            ent_d[i].v2 = cdb_data;
          end
          if (ent_d[i].q1 && ent_d[i].q2)
            ent_d[i].st = S_READY;
        end
        S_READY: begin
          if (disp_go && rdy_idx == IDX_W'(i))
            ent_d[i].st = S_EXEC;
        end
        S_EXEC: begin
          if (done_v && done_idx == IDX_W'(i))
            ent_d[i].st = S_FREE;
        end
        default: ent_d[i].st = S_FREE;
      endcase
      if (ent_d[i].st != S_FREE)
        cnt_d = cnt_d + ONE;
    end
  end

  always_ff @(posedge clk1 or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_RS; i++)
        ent_q[i] <= '0;
      busy_count <= '0;
      ex_b       <= 1'b0;
      rs_index   <= '0;
      rs1_data   <= '0;
      rs2_data   <= '0;
      func       <= '0;
      rob_ind    <= '0;
      rd         <= '0;
    end else begin
      for (int i = 0; i < NUM_RS; i++)
        ent_q[i] <= ent_d[i];
      busy_count <= cnt_d;
      ex_b       <= disp_go;
      if (disp_go) begin
        rs_index <= rdy_idx;
        rs1_data <= sel_ent.v1;
        rs2_data <= sel_ent.v2;
        func     <= sel_ent.func;
        rob_ind  <= sel_ent.rob;
        rd       <= sel_ent.rd;
      end
    end
  end

endmodule

// File: tb/tb_add_rs_dispatch.sv
// Scoreboard bench for add_rs_dispatch: directed scenarios then random
// traffic checked against a flag-based reference model.
module tb_add_rs_dispatch;

  localparam int NUM_RS = 3;
  localparam int DATA_W = 8;
  localparam int TAG_W  = 3;
  localparam int REG_W  = 4;
  localparam int IDX_W  = 2;

  logic              clk1 = 1'b0;
  logic              reset;
  logic              alloc_v;
  logic              alloc_rdy;
  logic [3:0]        alloc_func;
  logic [REG_W-1:0]  alloc_rd;
  logic [TAG_W-1:0]  alloc_rob;
  logic              alloc_q1_v;
  logic [DATA_W-1:0] alloc_v1;
  logic [TAG_W-1:0]  alloc_t1;
  logic              alloc_q2_v;
  logic [DATA_W-1:0] alloc_v2;
  logic [TAG_W-1:0]  alloc_t2;
  logic              cdb_v;
  logic [TAG_W-1:0]  cdb_tag;
  logic [DATA_W-1:0] cdb_data;
  logic              ex_rdy;
  logic              ex_b;
  logic [IDX_W-1:0]  rs_index;
  logic [DATA_W-1:0] rs1_data;
  logic [DATA_W-1:0] rs2_data;
  logic [3:0]        func;
  logic [TAG_W-1:0]  rob_ind;
  logic [REG_W-1:0]  rd;
  logic              done_v;
  logic [IDX_W-1:0]  done_idx;
  logic [IDX_W:0]    busy_count;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk1 = ~clk1;

  add_rs_dispatch #(
    .NUM_RS(NUM_RS), .DATA_W(DATA_W),
    .TAG_W(TAG_W), .REG_W(REG_W)
  ) dut (
    .clk1(clk1), .reset(reset),
    .alloc_v(alloc_v), .alloc_rdy(alloc_rdy),
    .alloc_func(alloc_func), .alloc_rd(alloc_rd),
    .alloc_rob(alloc_rob),
    .alloc_q1_v(alloc_q1_v), .alloc_v1(alloc_v1),
    .alloc_t1(alloc_t1),
    .alloc_q2_v(alloc_q2_v), .alloc_v2(alloc_v2),
    .alloc_t2(alloc_t2),
    .cdb_v(cdb_v), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .ex_rdy(ex_rdy), .ex_b(ex_b), .rs_index(rs_index),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .func(func), .rob_ind(rob_ind), .rd(rd),
    .done_v(done_v), .done_idx(done_idx),
    .busy_count(busy_count)
  );

  typedef struct {
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [3:0]        f;
    logic [TAG_W-1:0]  rob;
    logic [REG_W-1:0]  rd;
  } pkt_t;

  pkt_t exp_q[$];
  bit   exp_fire;

  // Reference model: per-slot occupancy / operand-present / sent flags.
  bit                m_busy [NUM_RS];
  bit                m_sent [NUM_RS];
  bit                m_h1   [NUM_RS];
  bit                m_h2   [NUM_RS];
  logic [DATA_W-1:0] m_a    [NUM_RS];
  logic [DATA_W-1:0] m_b    [NUM_RS];
  logic [TAG_W-1:0]  m_t1   [NUM_RS];
  logic [TAG_W-1:0]  m_t2   [NUM_RS];
  logic [TAG_W-1:0]  m_rob  [NUM_RS];
  logic [REG_W-1:0]  m_rd   [NUM_RS];
  logic [3:0]        m_f    [NUM_RS];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h @%0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic int model_count();
    int n = 0;
    for (int i = 0; i < NUM_RS; i++)
      if (m_busy[i]) n++;
    return n;
  endfunction

  function automatic int model_rdy();
    return (model_count() < NUM_RS) ? 1 : 0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NUM_RS; i++) begin
      m_busy[i] = 1'b0;
      m_sent[i] = 1'b0;
    end
    exp_q.delete();
    exp_fire = 1'b0;
  endtask

  task automatic model_step();
    bit o_busy [NUM_RS];
    bit o_sent [NUM_RS];
    bit o_h1 [NUM_RS];
    bit o_h2 [NUM_RS];
    int fi;
    int ri;
    int di;
    pkt_t p;
    o_busy = m_busy;
    o_sent = m_sent;
    o_h1 = m_h1;
    o_h2 = m_h2;
    fi = -1;
    ri = -1;
    for (int i = 0; i < NUM_RS; i++) begin
      if (!o_busy[i] && fi < 0) fi = i;
      if (o_busy[i] && o_h1[i] && o_h2[i] &&
          !o_sent[i] && ri < 0) ri = i;
    end
    exp_fire = 1'b0;
    if (ex_rdy && ri >= 0) begin
      p.idx = IDX_W'(ri);
      p.a   = m_a[ri];
      p.b   = m_b[ri];
      p.f   = m_f[ri];
      p.rob = m_rob[ri];
      p.rd  = m_rd[ri];
      exp_q.push_back(p);
      m_sent[ri] = 1'b1;
      exp_fire = 1'b1;
    end
    di = int'(done_idx);
    if (done_v && di < NUM_RS) begin
      if (o_busy[di] && o_sent[di]) begin
        m_busy[di] = 1'b0;
        m_sent[di] = 1'b0;
      end
    end
    for (int i = 0; i < NUM_RS; i++) begin
      if (o_busy[i] && cdb_v) begin
        if (!o_h1[i] && m_t1[i] == cdb_tag) begin
          m_h1[i] = 1'b1;
          m_a[i]  = cdb_data;
        end
        if (!o_h2[i] && m_t2[i] == cdb_tag) begin
          m_h2[i] = 1'b1;
          m_b[i]  = cdb_data;
        end
      end
    end
    if (alloc_v && fi >= 0 && alloc_func <= 4'd1) begin
      m_busy[fi] = 1'b1;
      m_sent[fi] = 1'b0;
      m_f[fi]    = alloc_func;
      m_rd[fi]   = alloc_rd;
      m_rob[fi]  = alloc_rob;
      m_t1[fi]   = alloc_t1;
      m_t2[fi]   = alloc_t2;
      m_h1[fi]   = alloc_q1_v ||
                   (cdb_v && cdb_tag == alloc_t1);
      m_h2[fi]   = alloc_q2_v ||
                   (cdb_v && cdb_tag == alloc_t2);
      m_a[fi]    = alloc_q1_v ? alloc_v1 : cdb_data;
      m_b[fi]    = alloc_q2_v ? alloc_v2 : cdb_data;
    end
  endtask

  always @(negedge clk1) begin
    pkt_t e;
    chk("ex_b", 32'(ex_b), 32'(exp_fire));
    chk("busy_count", 32'(busy_count), model_count());
    chk("alloc_rdy", 32'(alloc_rdy), model_rdy());
    if (ex_b) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL dispatch: unexpected ex_b idx=%0d @%0t",
                 rs_index, $time);
      end else begin
        e = exp_q.pop_front();
        chk("rs_index", 32'(rs_index), 32'(e.idx));
        chk("rs1_data", 32'(rs1_data), 32'(e.a));
        chk("rs2_data", 32'(rs2_data), 32'(e.b));
        chk("func", 32'(func), 32'(e.f));
        chk("rob_ind", 32'(rob_ind), 32'(e.rob));
        chk("rd", 32'(rd), 32'(e.rd));
      end
    end else if (exp_fire && exp_q.size() > 0) begin
      void'(exp_q.pop_front());
    end
  end

  task automatic cycle();
    @(posedge clk1);
    if (reset) model_reset();
    else model_step();
    #1;
  endtask

  task automatic do_alloc(input logic [3:0] f,
                          input logic [REG_W-1:0] r,
                          input logic [TAG_W-1:0] rb,
                          input logic q1,
                          input logic [DATA_W-1:0] a,
                          input logic [TAG_W-1:0] t1,
                          input logic q2,
                          input logic [DATA_W-1:0] b,
                          input logic [TAG_W-1:0] t2);
    alloc_v    = 1'b1;
    alloc_func = f;
    alloc_rd   = r;
    alloc_rob  = rb;
    alloc_q1_v = q1;
    alloc_v1   = a;
    alloc_t1   = t1;
    alloc_q2_v = q2;
    alloc_v2   = b;
    alloc_t2   = t2;
    cycle();
    alloc_v = 1'b0;
  endtask

  task automatic do_done(input int i);
    done_v   = 1'b1;
    done_idx = IDX_W'(i);
    cycle();
    done_v = 1'b0;
  endtask

  initial begin
    int ex_list[$];
    reset = 1'b1;
    alloc_v = 0; alloc_func = 0; alloc_rd = 0; alloc_rob = 0;
    alloc_q1_v = 0; alloc_v1 = 0; alloc_t1 = 0;
    alloc_q2_v = 0; alloc_v2 = 0; alloc_t2 = 0;
    cdb_v = 0; cdb_tag = 0; cdb_data = 0;
    ex_rdy = 0; done_v = 0; done_idx = 0;
    model_reset();
    repeat (3) cycle();
    reset = 1'b0;
    chk("rst_busy", 32'(busy_count), 0);
    chk("rst_ex_b", 32'(ex_b), 0);
    chk("rst_rs1", 32'(rs1_data), 0);

    // reset with two entries waiting
    do_alloc(4'd0, 4'd1, 3'd2, 1'b0, 8'd0, 3'd5, 1'b1, 8'd3, 3'd0);
    do_alloc(4'd1, 4'd2, 3'd3, 1'b0, 8'd0, 3'd6, 1'b1, 8'd4, 3'd0);
    chk("t1_busy2", 32'(busy_count), 2);
    reset = 1'b1;
    model_reset();
    cycle();
    reset = 1'b0;
    chk("t1_busy0", 32'(busy_count), 0);
    chk("t1_ex_b", 32'(ex_b), 0);
    chk("t1_rdy", 32'(alloc_rdy), 1);

    // both operands ready at issue
    ex_rdy = 1'b1;
    do_alloc(4'd0, 4'd3, 3'd1, 1'b1, 8'd5, 3'd0, 1'b1, 8'd7, 3'd0);
    chk("t2_no_early", 32'(ex_b), 0);
    cycle();
    chk("t2_ex_b", 32'(ex_b), 1);
    chk("t2_idx", 32'(rs_index), 0);
    chk("t2_rs1", 32'(rs1_data), 5);
    chk("t2_rs2", 32'(rs2_data), 7);
    chk("t2_func", 32'(func), 0);
    chk("t2_rob", 32'(rob_ind), 1);
    chk("t2_rd", 32'(rd), 3);
    cycle();
    chk("t2_one_shot", 32'(ex_b), 0);
    do_done(0);

    // wakeup from the CDB
    do_alloc(4'd1, 4'd2, 3'd3, 1'b1, 8'd8, 3'd0, 1'b0, 8'd0, 3'd4);
    cdb_v = 1'b1; cdb_tag = 3'd2; cdb_data = 8'hAA;
    cycle();
    chk("t3_no_wake", 32'(ex_b), 0);
    cdb_tag = 3'd4; cdb_data = 8'd9;
    cycle();
    cdb_v = 1'b0;
    chk("t3_wake_lat", 32'(ex_b), 0);
    cycle();
    chk("t3_ex_b", 32'(ex_b), 1);
    chk("t3_rs2", 32'(rs2_data), 9);
    chk("t3_rs1", 32'(rs1_data), 8);
    chk("t3_func", 32'(func), 1);
    do_done(0);

    // issue-time bypass
    cdb_v = 1'b1; cdb_tag = 3'd6; cdb_data = 8'h11;
    do_alloc(4'd0, 4'd5, 3'd2, 1'b0, 8'd0, 3'd6, 1'b1, 8'h22, 3'd0);
    cdb_v = 1'b0;
    cycle();
    chk("t4_ex_b", 32'(ex_b), 1);
    chk("t4_rs1", 32'(rs1_data), 32'h11);
    chk("t4_rs2", 32'(rs2_data), 32'h22);
    do_done(0);

    // full station, drop, free entry 1, refill
    ex_rdy = 1'b0;
    for (int i = 0; i < 3; i++)
      do_alloc(4'd0, 4'(i), 3'(i), 1'b1, 8'(i + 1), 3'd0,
               1'b1, 8'(i + 2), 3'd0);
    chk("t5_full", 32'(alloc_rdy), 0);
    chk("t5_busy3", 32'(busy_count), 3);
    do_alloc(4'd0, 4'd9, 3'd5, 1'b1, 8'd1, 3'd0, 1'b1, 8'd1, 3'd0);
    chk("t5_drop", 32'(busy_count), 3);
    ex_rdy = 1'b1;
    cycle();
    cycle();
    ex_rdy = 1'b0;
    do_done(1);
    chk("t5_rdy", 32'(alloc_rdy), 1);
    chk("t5_busy2", 32'(busy_count), 2);
    do_alloc(4'd0, 4'd9, 3'd7, 1'b1, 8'h33, 3'd0, 1'b1, 8'h44, 3'd0);
    ex_rdy = 1'b1;
    cycle();
    chk("t5_idx1", 32'(rs_index), 1);
    chk("t5_rob7", 32'(rob_ind), 7);
    cycle();
    chk("t5_idx2", 32'(rs_index), 2);
    ex_rdy = 1'b0;
    for (int i = 0; i < 3; i++) do_done(i);
    chk("t5_empty", 32'(busy_count), 0);

    // stall then in-order dispatch of 0 and 2
    do_alloc(4'd0, 4'd1, 3'd1, 1'b1, 8'd1, 3'd0, 1'b1, 8'd2, 3'd0);
    do_alloc(4'd1, 4'd2, 3'd2, 1'b0, 8'd0, 3'd5, 1'b1, 8'd3, 3'd0);
    do_alloc(4'd0, 4'd3, 3'd3, 1'b1, 8'd4, 3'd0, 1'b1, 8'd5, 3'd0);
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("t6_stall", 32'(ex_b), 0);
    end
    ex_rdy = 1'b1;
    cycle();
    chk("t6_first", 32'(rs_index), 0);
    cycle();
    chk("t6_second", 32'(rs_index), 2);
    ex_rdy = 1'b0;
    cdb_v = 1'b1; cdb_tag = 3'd5; cdb_data = 8'h5A;
    cycle();
    cdb_v = 1'b0;
    ex_rdy = 1'b1;
    cycle();
    chk("t6_third", 32'(rs_index), 1);
    chk("t6_rs1", 32'(rs1_data), 32'h5A);
    for (int i = 0; i < 3; i++) do_done(i);

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 499) == 0) begin
        reset = 1'b1;
        model_reset();
        cycle();
        reset = 1'b0;
        continue;
      end
      alloc_v    = ($urandom_range(0, 99) < 60);
      alloc_func = ($urandom_range(0, 9) == 0) ?
                   4'($urandom_range(2, 15)) :
                   4'($urandom_range(0, 1));
      alloc_rd   = 4'($urandom);
      alloc_rob  = 3'($urandom);
      alloc_q1_v = 1'($urandom_range(0, 1));
      alloc_v1   = 8'($urandom);
      alloc_t1   = 3'($urandom);
      alloc_q2_v = 1'($urandom_range(0, 1));
      alloc_v2   = 8'($urandom);
      alloc_t2   = 3'($urandom);
      cdb_v      = ($urandom_range(0, 99) < 50);
      cdb_tag    = 3'($urandom);
      cdb_data   = 8'($urandom);
      ex_rdy     = ($urandom_range(0, 99) < 70);
      done_v     = 1'b0;
      ex_list.delete();
      for (int i = 0; i < NUM_RS; i++)
        if (m_busy[i] && m_sent[i]) ex_list.push_back(i);
      if (ex_list.size() > 0 && $urandom_range(0, 99) < 50) begin
        done_v   = 1'b1;
        done_idx = IDX_W'(ex_list[$urandom_range(0, ex_list.size() - 1)]);
      end else if ($urandom_range(0, 99) < 5) begin
        done_v   = 1'b1;
        done_idx = IDX_W'($urandom_range(0, 3));
      end
      cycle();
    end

    alloc_v = 0; cdb_v = 0; done_v = 0; ex_rdy = 0;
    repeat (2) cycle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
